// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority-voted bit decisions, configurable
// frame format and a first-word-fall-through frame FIFO carrying per-frame error flags.
module uart_rx_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    output logic [DATA_BITS-1:0]          rd_data,
    output logic                          rd_ferr,
    output logic                          rd_perr,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic                          busy
);
    localparam int DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [TW-1:0] T_S0     = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_S1     = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_S2     = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_END    = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t               state, state_n;
    logic                 rx_p0, rxs, rxs_d;
    logic [DW-1:0]        div_cnt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic                 stop_idx;
    logic                 ferr_acc, perr_acc;
    logic                 s0, s1;
    logic [DATA_BITS-1:0] shreg;
    logic                 tick, samp_a, samp_b, decide, bit_end, maj, par_bad;
    logic                 push, pop, full, accept, drop;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [DATA_BITS+1:0] mem [FIFO_DEPTH];

    // Stage 0/1: two-flop synchroniser plus one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p0 <= 1'b1;
            rxs   <= 1'b1;
            rxs_d <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rxs   <= rx_p0;
            rxs_d <= rxs;
        end
    end

    assign tick    = (div_cnt == DIV_LAST);
    assign samp_a  = tick && (tick_cnt == T_S0);
    assign samp_b  = tick && (tick_cnt == T_S1);
    assign decide  = tick && (tick_cnt == T_S2);
    assign bit_end = tick && (tick_cnt == T_END);
    assign maj     = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign par_bad = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        push    = 1'b0;
        case (state)
            IDLE:  if (rxs_d && !rxs) state_n = START;
            START: begin
                if (decide && maj)  state_n = IDLE;
                else if (bit_end)   state_n = DATA;
            end
            DATA:  if (bit_end && bit_idx == BIT_LAST) state_n = (PARITY != 0) ? PAR : STOP;
            PAR:   if (bit_end) state_n = STOP;
            STOP: begin
                if (decide && stop_idx == STOP_LAST) begin
                    state_n = IDLE;
                    push    = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bit timing restarts from zero whenever the receiver sits in IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
        end else if (state == IDLE) begin
            div_cnt  <= '0;
            tick_cnt <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            ferr_acc <= 1'b0;
            perr_acc <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) tick_cnt <= (tick_cnt == T_END) ? '0 : tick_cnt + 1'b1;
            if (state == DATA && bit_end && bit_idx != BIT_LAST) bit_idx <= bit_idx + 1'b1;
            if (state == PAR && decide) perr_acc <= par_bad;
            if (state == STOP && decide && !maj) ferr_acc <= 1'b1;
            if (state == STOP && bit_end) stop_idx <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (samp_a) s0 <= rxs;
        if (samp_b) s1 <= rxs;
        if (state == DATA && decide) shreg <= {maj, shreg[DATA_BITS-1:1]};
    end

    // A full FIFO still accepts a frame when the head is popped on the same edge
    assign pop      = rd_valid && rd_ready;
    assign full     = (fifo_count == FULL_CNT);
    assign accept   = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign rd_valid = (fifo_count != '0);
    assign {rd_perr, rd_ferr, rd_data} = rd_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= {perr_acc, ferr_acc | ~maj, shreg};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overrun    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: default 8N1 instance plus an even-parity instance.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
    localparam int BIT = 8680;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1, rd_ready = 1'b0, clr_overrun = 1'b0;
    logic [7:0] rd_data;
    logic       rd_ferr, rd_perr, rd_valid, overrun, busy;
    logic [3:0] fifo_count;

    logic       rx_p = 1'b1, rd_ready_p = 1'b0, clr_overrun_p = 1'b0;
    logic [7:0] rd_data_p;
    logic       rd_ferr_p, rd_perr_p, rd_valid_p, overrun_p, busy_p;
    logic [3:0] fifo_count_p;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #10 clk = ~clk;

    uart_rx_fifo dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_data(rd_data), .rd_ferr(rd_ferr),
        .rd_perr(rd_perr), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .fifo_count(fifo_count), .overrun(overrun), .clr_overrun(clr_overrun), .busy(busy)
    );

    uart_rx_fifo #(.PARITY(2)) dut_p (
        .clk(clk), .reset(reset), .rx(rx_p), .rd_data(rd_data_p), .rd_ferr(rd_ferr_p),
        .rd_perr(rd_perr_p), .rd_valid(rd_valid_p), .rd_ready(rd_ready_p),
        .fifo_count(fifo_count_p), .overrun(overrun_p), .clr_overrun(clr_overrun_p),
        .busy(busy_p)
    );

    typedef struct {
        logic [7:0] data;
        logic       stop_val;
        logic [7:0] exp_data;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic send_main(input logic [7:0] d, input logic stop_val);
        rx = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            #BIT;
        end
        rx = stop_val;
        #BIT;
        rx = 1'b1;
    endtask

    task automatic send_par(input logic [7:0] d, input logic par_bit);
        rx_p = 1'b0;
        #BIT;
        for (int i = 0; i < 8; i++) begin
            rx_p = d[i];
            #BIT;
        end
        rx_p = par_bit;
        #BIT;
        rx_p = 1'b1;
        #BIT;
    endtask

    task automatic pop_main();
        @(negedge clk) rd_ready = 1'b1;
        @(negedge clk) rd_ready = 1'b0;
    endtask

    task automatic pop_par();
        @(negedge clk) rd_ready_p = 1'b1;
        @(negedge clk) rd_ready_p = 1'b0;
    endtask

    initial begin
        time t0, t_rise;
        bit  found;

        vecs[0] = '{data: 8'h3C, stop_val: 1'b0, exp_data: 8'h3C, exp_ferr: 1'b1};
        vecs[1] = '{data: 8'h55, stop_val: 1'b1, exp_data: 8'h55, exp_ferr: 1'b0};
        vecs[2] = '{data: 8'hFF, stop_val: 1'b1, exp_data: 8'hFF, exp_ferr: 1'b0};

        #5 reset = 1'b0;
        #40;
        check("reset_rd_valid", rd_valid, 0);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_busy", busy, 0);
        check("reset_overrun", overrun, 0);
        check("reset_rd_data", rd_data, 0);
        @(negedge clk) reset = 1'b1;
        #BIT;

        // Single 0xA5 frame with rd_valid latency measured from the stop bit start
        found = 1'b0;
        t_rise = 0;
        fork
            send_main(8'hA5, 1'b1);
            begin
                #(9 * BIT);
                t0 = $time;
                check("valid_before_stop", rd_valid, 0);
                for (int c = 0; c < 2 * BIT / 20 && !found; c++) begin
                    @(negedge clk);
                    if (rd_valid) begin
                        found = 1'b1;
                        t_rise = $time;
                    end
                end
            end
        join
        total_cnt++;
        if (found && (t_rise - t0) <= 3 * BIT / 2) pass_cnt++;
        else $display("FAIL valid_latency: found=%0d delay=%0t, expected within %0d ns", found, t_rise - t0, 3 * BIT / 2);
        #BIT;
        check("a5_count", fifo_count, 1);
        check("a5_data", rd_data, 8'hA5);
        check("a5_ferr", rd_ferr, 0);
        check("a5_perr", rd_perr, 0);
        pop_main();
        check("a5_count_after_pop", fifo_count, 0);

        // Glitch shorter than half a bit must be rejected
        @(negedge clk) rx = 1'b0;
        #200;
        check("glitch_busy_high", busy, 1);
        #1800;
        rx = 1'b1;
        #BIT;
        check("glitch_busy_low", busy, 0);
        check("glitch_count", fifo_count, 0);
        check("glitch_overrun", overrun, 0);

        // Table frames on the 8N1 instance, parity frames on the other instance
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    send_main(vecs[i].data, vecs[i].stop_val);
                    #BIT;
                    check($sformatf("vec%0d_count", i), fifo_count, 1);
                    check($sformatf("vec%0d_data", i), rd_data, vecs[i].exp_data);
                    check($sformatf("vec%0d_ferr", i), rd_ferr, vecs[i].exp_ferr);
                    check($sformatf("vec%0d_perr", i), rd_perr, 0);
                    pop_main();
                    check($sformatf("vec%0d_popped", i), fifo_count, 0);
                end
            end
            begin
                send_par(8'h3C, 1'b0);
                send_par(8'h3D, 1'b0);
                @(negedge clk);
                check("par_count", fifo_count_p, 2);
                check("par0_data", rd_data_p, 8'h3C);
                check("par0_perr", rd_perr_p, 0);
                pop_par();
                check("par1_data", rd_data_p, 8'h3D);
                check("par1_perr", rd_perr_p, 1);
                check("par1_ferr", rd_ferr_p, 0);
                pop_par();
                check("par_empty", rd_valid_p, 0);
            end
        join

        // Overrun: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_main(8'(i), 1'b1);
        #BIT;
        @(negedge clk);
        check("ovr_count_full", fifo_count, 8);
        check("ovr_flag", overrun, 1);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("ovr_read%0d", i), rd_data, 8'(i));
            pop_main();
        end
        check("ovr_count_empty", fifo_count, 0);
        check("ovr_valid_empty", rd_valid, 0);
        check("ovr_sticky", overrun, 1);
        @(negedge clk) clr_overrun = 1'b1;
        @(negedge clk) clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Asynchronous reset in the middle of a frame with an entry already stored
        send_main(8'h11, 1'b1);
        #BIT;
        fork
            send_main(8'h22, 1'b1);
            begin
                #(4 * BIT + 3000);
                @(posedge clk);
                #3;
                check("pre_reset_busy", busy, 1);
                check("pre_reset_count", fifo_count, 1);
                reset = 1'b0;
                #2;
                check("async_rd_valid", rd_valid, 0);
                check("async_count", fifo_count, 0);
                check("async_rd_data", rd_data, 0);
                check("async_busy", busy, 0);
                check("async_ferr", rd_ferr, 0);
            end
        join
        #BIT;
        @(negedge clk) reset = 1'b1;
        #BIT;
        send_main(8'h7E, 1'b1);
        #BIT;
        check("post_reset_count", fifo_count, 1);
        check("post_reset_data", rd_data, 8'h7E);
        check("post_reset_ferr", rd_ferr, 0);
        pop_main();
        check("post_reset_empty", fifo_count, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver that succeeds the fixed 8N1 receive path of serialDevice. It adds 16x oversampling with majority voting, configurable frame format (data bits, parity, stop bits), and false-start rejection. Received frames are buffered in a first-word-fall-through FIFO with per-frame error flags and a valid/ready read port. It sits between the rx pin and the consumer logic (LCD/command path).

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.
DATA_BITS, 8, payload bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; 1 or 2.
FIFO_DEPTH, 8, FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-low reset.
rx  in  1  serial input; asynchronous; idle level 1.
rd_data  out  DATA_BITS  payload of the FIFO head entry, LSB = first bit received.
rd_ferr  out  1  framing error flag of the head entry.
rd_perr  out  1  parity error flag of the head entry; always 0 when PARITY = 0.
rd_valid  out  1  FIFO not empty.
rd_ready  in  1  consumer accepts the head entry.
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
overrun  out  1  sticky: a frame was dropped because the FIFO was full.
clr_overrun  in  1  synchronous one-cycle clear of overrun.
busy  out  1  receiver is not in IDLE.

Behaviour:
- Reset (reset = 0, asynchronous): every output is 0 (rd_data, rd_ferr, rd_perr, rd_valid, fifo_count, overrun, busy). FSM goes to IDLE, the FIFO is emptied, and the synchroniser flops are preset to 1. Reset mid-frame discards the partial frame.
- Synchroniser: rx passes through 2 flops (rxs). All decisions below use rxs.
- Tick generator: DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer truncation; the default is 27, giving a 432-clock bit (0.46% error). It emits a 1-clk tick every DIV clocks and restarts at 0 on the IDLE-to-START transition.
- Sample point: each bit is resolved by a 2-of-3 majority over ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 counted within that bit.
- FSM states:
  - IDLE: a 1-to-0 transition on rxs moves to START.
  - START: if the majority value is 1, the start is false; return to IDLE, nothing is stored and no flag is set. Otherwise wait to the end of the bit and go to DATA.
  - DATA: shift in DATA_BITS bits, LSB first. Then go to PARITY if PARITY != 0, else to STOP.
  - PARITY: the received bit is compared with the computed parity. Odd mode requires XOR(data, p) = 1; even mode requires XOR(data, p) = 0. A mismatch sets perr for the frame.
  - STOP: each stop bit is resolved by majority. Any stop bit resolving to 0 sets ferr, but the frame is still stored. The frame is pushed on the clock of the last stop bit's majority decision, and the FSM returns to IDLE on that same edge. A new start can therefore be detected from mid-stop-bit onward.
- busy is high in every state except IDLE.
- Push latency: rd_valid rises 1 clk after the push edge if the FIFO was empty.
- FIFO: first-word-fall-through. A pop occurs when rd_valid && rd_ready; rd_data, rd_ferr and rd_perr update the clk after the pop.
  - Push with count < FIFO_DEPTH: the frame is stored.
  - Push when full with a pop in the same clk: the push is accepted and count is unchanged.
  - Push when full with no pop: the frame is dropped, overrun is set, and FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count goes from 0 to FIFO_DEPTH with no wrap.
- overrun stays set until clr_overrun. If a clear and a new overrun occur in the same clk, set wins.
- rd_ready while empty has no effect.

Test Plan:
1. Defaults, 8680 ns/bit. Send 0xA5 (8N1). -> Exactly one entry: rd_data = 0xA5, rd_ferr = 0, rd_perr = 0. rd_valid rises about half a bit time (±1 bit) after the stop bit starts. fifo_count = 1.
2. Glitch: drive rx low for 2000 ns, then return to 1. -> busy pulses, then returns to 0 within 1 bit time. No entry is stored; fifo_count = 0 and overrun = 0.
3. Framing: send 0x3C with the stop bit driven 0, then rx = 1. -> Entry stored with rd_data = 0x3C and rd_ferr = 1. A following valid 0x55 frame is stored with rd_ferr = 0.
4. Parity: instance with PARITY = 2. Send 0x3C with parity bit 0, then 0x3D with parity bit 0. -> First entry rd_perr = 0; second entry rd_perr = 1.
5. Overrun: hold rd_ready = 0 and send 9 frames 0x01..0x09. -> fifo_count = 8 and overrun = 1. Then hold rd_ready = 1. -> Entries read out in order 0x01..0x08 (0x09 absent), fifo_count reaches 0. Pulse clr_overrun. -> overrun = 0.
6. Reset mid-frame: pull reset low during the 4th data bit of a frame. -> All outputs read 0 immediately, without waiting for a clock edge. After release, a fresh 0x7E frame is received correctly with nothing else stored.
